// File: rtl/output_controller.sv
// Streams one CODE_LENGTH-beat frame from the result BRAM out over AXI-Stream
// while the top-level state equals OUTPUT_STATE; a 2-entry skid FIFO absorbs the 1-cycle BRAM latency.
module output_controller #(
  parameter int                     CODE_LENGTH  = 1024,
  parameter int                     ADDR_WIDTH   = 10,
  parameter int                     DATA_WIDTH   = 8,
  parameter int                     STATE_WIDTH  = 10,
  parameter logic [STATE_WIDTH-1:0] OUTPUT_STATE = 10'd4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STATE_WIDTH-1:0] state,
  output logic [ADDR_WIDTH-1:0]  addr_to_result_bram,
  output logic                   enable_to_result_bram,
  input  logic [DATA_WIDTH-1:0]  data_from_result_bram,
  output logic                   maxis_tvalid,
  input  logic                   maxis_tready,
  output logic [DATA_WIDTH-1:0]  maxis_tdata,
  output logic                   maxis_tlast,
  output logic                   done,
  output logic                   error
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CODE_LEN_C = CNT_W'(CODE_LENGTH);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(CODE_LENGTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]            fsm;
  logic [CNT_W-1:0]      rd_cnt;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  inflight;
  logic                  inflight_last;
  logic [DATA_WIDTH-1:0] fifo_dat [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic       in_out;
  logic       streaming;
  logic       abort;
  logic       fire;
  logic       last_beat;
  logic [2:0] pending;

  assign in_out    = (state == OUTPUT_STATE);
  assign streaming = (fsm == S_STREAM);
  assign abort     = streaming && !in_out;
  assign fire      = maxis_tvalid && maxis_tready;
  assign last_beat = fire && (beat_cnt == LAST_IDX);

  // Occupancy net of this cycle's pop, so a steady tready sustains one beat per cycle.
  assign pending = {1'b0, count} + {2'b0, inflight} - {2'b0, fire};

  assign enable_to_result_bram = streaming && in_out && (rd_cnt < CODE_LEN_C) && (pending < 3'd2);
  assign addr_to_result_bram   = rd_cnt[ADDR_WIDTH-1:0];

  assign maxis_tvalid = (count != 2'd0);
  assign maxis_tdata  = maxis_tvalid ? fifo_dat[rd_ptr] : '0;
  assign maxis_tlast  = maxis_tvalid && fifo_last[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm           <= S_IDLE;
      rd_cnt        <= '0;
      beat_cnt      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_dat[0]   <= '0;
      fifo_dat[1]   <= '0;
      fifo_last     <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (in_out) begin
            fsm      <= S_STREAM;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            error    <= 1'b0;
          end
        end
        S_STREAM: begin
          if (abort) begin
            fsm      <= S_IDLE;
            error    <= 1'b1;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
          end else begin
            inflight <= enable_to_result_bram;
            if (enable_to_result_bram) begin
              rd_cnt        <= rd_cnt + 1'b1;
              inflight_last <= (rd_cnt == LAST_IDX);
            end
            // BRAM data is valid the cycle after the read, so the push lags by one.
            if (inflight) begin
              fifo_dat[wr_ptr]  <= data_from_result_bram;
              fifo_last[wr_ptr] <= inflight_last;
              wr_ptr            <= ~wr_ptr;
            end
            if (fire) begin
              rd_ptr   <= ~rd_ptr;
              beat_cnt <= beat_cnt + 1'b1;
            end
            count <= count + {1'b0, inflight} - {1'b0, fire};
            if (last_beat) begin
              fsm  <= S_DONE;
              done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!in_out) fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
